// File: rtl/matrix_result_reader.sv
// Streams the DIM x DIM result matrix out of a synchronous-read RAM in row-major
// order on a valid/ready port, throttling reads so the holding FIFO never overflows.
module matrix_result_reader #(
  parameter int DATA_W     = 16,
  parameter int DIM        = 4,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_row,
  output logic [1:0]        m_col,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int N     = DIM * DIM;
  localparam int CNT_W = ADDR_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 3) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_issue, w_issue_nxt;
  logic [ADDR_W-1:0]  r_out,   w_out_nxt;
  logic [ADDR_W-1:0]  r_addr,  w_addr_nxt;
  logic               w_issue;
  // [0]: read presented to the RAM this cycle, [1]: RAM data returning this cycle
  logic [1:0]         r_rd_pipe;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [OCC_W-1:0]   r_cnt;
  logic [OCC_W-1:0]   w_occ;
  logic               w_push, w_pop, w_room;
  logic [31:0]        w_idx;

  assign w_push = r_rd_pipe[1];
  assign w_pop  = m_valid & m_ready;
  // Everything already committed to the FIFO, net of the element leaving now
  assign w_occ  = r_cnt + OCC_W'(r_rd_pipe[0]) + OCC_W'(r_rd_pipe[1]) - OCC_W'(w_pop);
  assign w_room = (w_occ < OCC_W'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_issue_nxt = r_issue;
    w_out_nxt   = r_out;
    w_addr_nxt  = r_addr;
    unique case (r_state)
      S_IDLE: begin
        // Address 0 goes out on the accepting edge itself to hit the 3-cycle latency
        if (start) begin
          w_state_nxt = S_RUN;
          w_issue     = 1'b1;
          w_addr_nxt  = '0;
          w_issue_nxt = CNT_W'(1);
          w_out_nxt   = '0;
        end
      end
      S_RUN: begin
        if ((r_issue < CNT_W'(N)) && w_room) begin
          w_issue     = 1'b1;
          w_addr_nxt  = r_issue[ADDR_W-1:0];
          w_issue_nxt = r_issue + CNT_W'(1);
        end
        if (w_pop) begin
          w_out_nxt = r_out + ADDR_W'(1);
          if (r_out == ADDR_W'(N - 1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_issue   <= '0;
      r_out     <= '0;
      r_addr    <= '0;
      r_rd_pipe <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_issue   <= w_issue_nxt;
      r_out     <= w_out_nxt;
      r_addr    <= w_addr_nxt;
      r_rd_pipe <= {r_rd_pipe[0], w_issue};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= ram_dout;
        r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
      end
      if (w_pop)
        r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      r_cnt <= r_cnt + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  assign w_idx    = 32'(r_out);
  assign ram_addr = r_addr;
  assign ram_ren  = r_rd_pipe[0];
  assign m_valid  = (r_cnt != '0);
  assign m_data   = m_valid ? r_mem[r_rptr] : '0;
  assign m_row    = 2'(w_idx / DIM);
  assign m_col    = 2'(w_idx % DIM);
  assign m_last   = m_valid && (r_out == ADDR_W'(N - 1));
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_push && !w_pop && (r_cnt == OCC_W'(FIFO_DEPTH))));

endmodule
